// File: rtl/key_frame_sched_if.sv
// Bus bundle for key_frame_sched: the SPI byte-read handshake plus the
// single-port snapshot RAM port. The scheduler side is the master.
interface key_frame_sched_if;
  // SPI register-read side
  logic       cs_i;
  logic       rd_req_i;
  logic [7:0] rd_addr_i;
  logic [7:0] rd_data_o;
  logic       rd_ack_o;
  // Snapshot RAM side
  logic [7:0] ram_addr_o;
  logic       ram_we_o;
  logic [7:0] ram_wdata_o;
  logic [7:0] ram_rdata_i;

  modport master (
    input  cs_i, rd_req_i, rd_addr_i, ram_rdata_i,
    output rd_data_o, rd_ack_o, ram_addr_o, ram_we_o, ram_wdata_o
  );

  modport slave (
    output cs_i, rd_req_i, rd_addr_i, ram_rdata_i,
    input  rd_data_o, rd_ack_o, ram_addr_o, ram_we_o, ram_wdata_o
  );
endinterface

// File: rtl/key_frame_sched.sv
// key_frame_sched: owns the single-port key snapshot RAM. Periodically
// snapshots the padded key vector and writes it as 8-bit groups, serves
// SPI byte reads through the same port, and holds frame updates off while
// chip-select is active so the host always sees one coherent frame.
module key_frame_sched #(
  parameter int NUM_GROUPS = 8,
  parameter int SCAN_DIV   = 778
) (
  input  logic                    clk_g_i,
  input  logic                    rstn_g_i,
  input  logic [NUM_GROUPS*8-1:0] keys_i,
  key_frame_sched_if.master       bus,
  output logic [7:0]              frame_cnt_o,
  output logic                    err_o
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, RD_DONE, SCAN} state_t;

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       NG       = 8'(NUM_GROUPS);
  localparam logic [7:0]       LAST_IDX = 8'(NUM_GROUPS - 1);

  state_t                  state_reg, state_next;
  logic [DIV_W-1:0]        div_reg, div_next;
  logic                    scan_pend_reg, scan_pend_next;
  logic                    pend_valid_reg, pend_valid_next;
  logic [7:0]              pend_addr_reg, pend_addr_next;
  logic [7:0]              rd_addr_reg, rd_addr_next;
  logic [7:0]              idx_reg, idx_next;
  logic [NUM_GROUPS*8-1:0] snap_reg, snap_next;
  logic [7:0]              rd_data_reg, rd_data_next;
  logic                    rd_ack_reg, rd_ack_next;
  logic [7:0]              ram_addr_reg, ram_addr_next;
  logic                    ram_we_reg, ram_we_next;
  logic [7:0]              ram_wdata_reg, ram_wdata_next;
  logic [7:0]              frame_cnt_reg, frame_cnt_next;
  logic                    err_reg, err_next;

  logic                    tick;
  logic                    req_valid;
  logic                    scan_start;
  logic [7:0]              start_addr;
  logic [7:0]              idx_step;

  // Snapshot viewed as a full 256-entry group table so an 8-bit index
  // selects directly; entries beyond NUM_GROUPS read as zero.
  logic [7:0] snap_group [0:255];

  for (genvar gi = 0; gi < 256; gi++) begin : g_group
    if (gi < NUM_GROUPS) begin : g_used
      assign snap_group[gi] = snap_reg[gi*8 +: 8];
    end else begin : g_unused
      assign snap_group[gi] = 8'h00;
    end
  end

  // Divider wrap produces the frame-update tick; reads with cs high are ignored.
  assign tick      = (div_reg == DIV_LAST);
  assign req_valid = bus.rd_req_i && !bus.cs_i;
  assign idx_step  = idx_reg + 8'd1;

  // Next-state and registered-output logic for the scheduler.
  always_comb begin
    state_next      = state_reg;
    div_next        = tick ? '0 : div_reg + DIV_W'(1);
    scan_pend_next  = scan_pend_reg;
    pend_valid_next = pend_valid_reg;
    pend_addr_next  = pend_addr_reg;
    rd_addr_next    = rd_addr_reg;
    idx_next        = idx_reg;
    snap_next       = snap_reg;
    rd_data_next    = rd_data_reg;
    rd_ack_next     = 1'b0;
    ram_addr_next   = ram_addr_reg;
    ram_we_next     = 1'b0;
    ram_wdata_next  = ram_wdata_reg;
    frame_cnt_next  = frame_cnt_reg;
    err_next        = err_reg;
    scan_start      = 1'b0;
    start_addr      = 8'h00;

    case (state_reg)
      // RD_DONE's exit edge arbitrates exactly like IDLE, which is what
      // lets reads be sustained every 3 cycles.
      IDLE, RD_DONE: begin
        if (pend_valid_reg || req_valid) begin
          start_addr   = pend_valid_reg ? pend_addr_reg : bus.rd_addr_i;
          rd_addr_next = start_addr;
          if (start_addr < NG) begin
            ram_addr_next = start_addr;
          end
          state_next = RD_ADDR;
          // Servicing the held read frees the slot; a fresh request refills it.
          if (pend_valid_reg) begin
            pend_valid_next = req_valid;
            if (req_valid) begin
              pend_addr_next = bus.rd_addr_i;
            end
          end
        end else if (scan_pend_reg && bus.cs_i) begin
          scan_start     = 1'b1;
          snap_next      = keys_i;
          idx_next       = 8'h00;
          ram_we_next    = 1'b1;
          ram_addr_next  = 8'h00;
          ram_wdata_next = keys_i[7:0];
          state_next     = SCAN;
        end else begin
          state_next = IDLE;
        end
      end

      RD_ADDR: begin
        state_next = RD_WAIT;
      end

      // RAM data is valid now; every address class completes here.
      RD_WAIT: begin
        if (rd_addr_reg < NG) begin
          rd_data_next = bus.ram_rdata_i;
        end else if (rd_addr_reg == NG) begin
          rd_data_next = frame_cnt_reg;
        end else begin
          rd_data_next = 8'h00;
        end
        rd_ack_next = 1'b1;
        state_next  = RD_DONE;
      end

      SCAN: begin
        if (idx_reg == LAST_IDX) begin
          frame_cnt_next = frame_cnt_reg + 8'd1;
          state_next     = IDLE;
        end else begin
          idx_next       = idx_step;
          ram_we_next    = 1'b1;
          ram_addr_next  = idx_step;
          ram_wdata_next = snap_group[idx_step];
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Requests arriving while busy are held in the one-deep slot.
    if (req_valid && (state_reg inside {RD_ADDR, RD_WAIT, SCAN})) begin
      if (pend_valid_reg) begin
        err_next = 1'b1;
      end else begin
        pend_valid_next = 1'b1;
        pend_addr_next  = bus.rd_addr_i;
      end
    end

    // A tick landing on the scan-start edge becomes the next pending scan.
    if (tick) begin
      scan_pend_next = 1'b1;
      if (scan_pend_reg && !scan_start) begin
        err_next = 1'b1;
      end
    end else if (scan_start) begin
      scan_pend_next = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and output registers; reset drops any operation in flight.
  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      div_reg        <= '0;
      scan_pend_reg  <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= 8'h00;
      rd_addr_reg    <= 8'h00;
      idx_reg        <= 8'h00;
      snap_reg       <= '0;
      rd_data_reg    <= 8'h00;
      rd_ack_reg     <= 1'b0;
      ram_addr_reg   <= 8'h00;
      ram_we_reg     <= 1'b0;
      ram_wdata_reg  <= 8'h00;
      frame_cnt_reg  <= 8'h00;
      err_reg        <= 1'b0;
    end else begin
      div_reg        <= div_next;
      scan_pend_reg  <= scan_pend_next;
      pend_valid_reg <= pend_valid_next;
      pend_addr_reg  <= pend_addr_next;
      rd_addr_reg    <= rd_addr_next;
      idx_reg        <= idx_next;
      snap_reg       <= snap_next;
      rd_data_reg    <= rd_data_next;
      rd_ack_reg     <= rd_ack_next;
      ram_addr_reg   <= ram_addr_next;
      ram_we_reg     <= ram_we_next;
      ram_wdata_reg  <= ram_wdata_next;
      frame_cnt_reg  <= frame_cnt_next;
      err_reg        <= err_next;
    end
  end

  assign bus.rd_data_o   = rd_data_reg;
  assign bus.rd_ack_o    = rd_ack_reg;
  assign bus.ram_addr_o  = ram_addr_reg;
  assign bus.ram_we_o    = ram_we_reg;
  assign bus.ram_wdata_o = ram_wdata_reg;
  assign frame_cnt_o     = frame_cnt_reg;
  assign err_o           = err_reg;

endmodule

// File: tb/tb_key_frame_sched.sv
// Directed bench for key_frame_sched with a behavioural snapshot RAM.
module tb_key_frame_sched;
  localparam int NG  = 8;
  localparam int DIV = 20;

  logic          clk;
  logic          rstn;
  logic [NG*8-1:0] keys;
  logic [7:0]    frame_cnt;
  logic          err;

  key_frame_sched_if bus();

  key_frame_sched #(.NUM_GROUPS(NG), .SCAN_DIV(DIV)) dut (
    .clk_g_i    (clk),
    .rstn_g_i   (rstn),
    .keys_i     (keys),
    .bus        (bus),
    .frame_cnt_o(frame_cnt),
    .err_o      (err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int we_count = 0;
  int ack_count = 0;
  int run_len = 0;
  int runs = 0;
  int bad_runs = 0;
  logic [7:0] mem [0:255];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and write/ack activity monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_we_o) we_count <= we_count + 1;
    if (bus.rd_ack_o) ack_count <= ack_count + 1;
    if (bus.ram_we_o) begin
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      runs <= runs + 1;
      if (run_len != NG) bad_runs <= bad_runs + 1;
      run_len <= 0;
    end
  end

  // Single-port RAM with one-cycle registered read.
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
    bus.ram_rdata_i <= mem[bus.ram_addr_o];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus.rd_req_i  = 1'b1;
    bus.rd_addr_i = a;
    step();
    bus.rd_req_i = 1'b0;
    check(bus.rd_ack_o, 1'b0, {tag, "_n0"});
    step();
    check(bus.rd_ack_o, 1'b0, {tag, "_n1"});
    step();
    check(bus.rd_ack_o, 1'b1, {tag, "_ack"});
    check(bus.rd_data_o, exp, {tag, "_data"});
    $display("read addr=%0h data=%0h", a, bus.rd_data_o);
    step();
    check(bus.rd_ack_o, 1'b0, {tag, "_ackdrop"});
  endtask

  int base, base2, a0, a1, w0, r0, b0;

  initial begin
    rstn = 1'b0;
    keys = 64'h0807060504030201;
    bus.cs_i = 1'b1;
    bus.rd_req_i = 1'b0;
    bus.rd_addr_i = 8'h00;
    repeat (3) step();

    // Reset values
    check(bus.rd_data_o, 8'h00, "rst_rd_data");
    check(bus.rd_ack_o, 1'b0, "rst_rd_ack");
    check(bus.ram_addr_o, 8'h00, "rst_ram_addr");
    check(bus.ram_we_o, 1'b0, "rst_ram_we");
    check(bus.ram_wdata_o, 8'h00, "rst_ram_wdata");
    check(frame_cnt, 8'h00, "rst_frame_cnt");
    check(err, 1'b0, "rst_err");
    rstn = 1'b1;
    base = cyc;

    // Read with cs high is ignored
    bus.rd_req_i = 1'b1;
    bus.rd_addr_i = 8'h03;
    a0 = ack_count;
    step();
    bus.rd_req_i = 1'b0;
    goto_edge(base + 8);
    check(ack_count - a0, 0, "cs_hi_no_ack");
    check(err, 1'b0, "cs_hi_no_err");

    // First frame: tick after DIV cycles, writes 0x01..0x08
    goto_edge(base + 20);
    check(bus.ram_we_o, 1'b0, "pre_tick_we");
    check(we_count, 0, "pre_tick_wecount");
    for (int i = 0; i < NG; i++) begin
      goto_edge(base + 21 + i);
      check(bus.ram_we_o, 1'b1, $sformatf("scan1_we%0d", i));
      check(bus.ram_addr_o, 8'(i), $sformatf("scan1_addr%0d", i));
      check(bus.ram_wdata_o, 8'(i + 1), $sformatf("scan1_data%0d", i));
      $display("write addr=%0h data=%0h", bus.ram_addr_o, bus.ram_wdata_o);
    end
    goto_edge(base + 29);
    check(bus.ram_we_o, 1'b0, "scan1_we_end");
    check(frame_cnt, 8'h01, "scan1_frame_cnt");

    // Reads with cs low
    bus.cs_i = 1'b0;
    do_read(8'h03, 8'h04, "rd_grp3");
    do_read(8'h08, 8'h01, "rd_frame");
    do_read(8'h40, 8'h00, "rd_unmapped");
    do_read(8'h07, 8'h08, "rd_grp7");

    // Back-to-back reads 3 cycles apart
    bus.rd_req_i = 1'b1;
    bus.rd_addr_i = 8'h00;
    step();
    bus.rd_req_i = 1'b0;
    step();
    step();
    check(bus.rd_ack_o, 1'b1, "b2b_ack0");
    check(bus.rd_data_o, 8'h01, "b2b_data0");
    $display("read addr=0 data=%0h", bus.rd_data_o);
    bus.rd_req_i = 1'b1;
    bus.rd_addr_i = 8'h05;
    step();
    bus.rd_req_i = 1'b0;
    check(bus.rd_ack_o, 1'b0, "b2b_gap");
    step();
    step();
    check(bus.rd_ack_o, 1'b1, "b2b_ack1");
    check(bus.rd_data_o, 8'h06, "b2b_data1");
    $display("read addr=5 data=%0h", bus.rd_data_o);

    // Deferral: cs low across ticks at base+40/60/80
    goto_edge(base + 59);
    check(err, 1'b0, "defer_err_before");
    goto_edge(base + 60);
    check(err, 1'b1, "defer_err_coalesce");
    goto_edge(base + 81);
    check(we_count, NG, "defer_no_writes");
    bus.cs_i = 1'b1;
    goto_edge(base + 95);
    check(we_count, 2 * NG, "defer_one_scan");
    check(frame_cnt, 8'h02, "defer_frame_cnt");
    $display("deferred scan frame_cnt=%0d", frame_cnt);
    keys = 64'h2827262524232221;

    // Reset in scan cycle 4 (scan accepted at base+101)
    goto_edge(base + 105);
    check(bus.ram_we_o, 1'b1, "midscan_we");
    check(bus.ram_addr_o, 8'h04, "midscan_addr");
    #2;
    rstn = 1'b0;
    #1;
    check(bus.ram_we_o, 1'b0, "async_rst_we");
    check(frame_cnt, 8'h00, "async_rst_frame");
    check(err, 1'b0, "async_rst_err");
    step();
    step();
    rstn = 1'b1;
    base2 = cyc;
    w0 = we_count;
    goto_edge(base2 + 20);
    check(bus.ram_we_o, 1'b0, "post_rst_no_we");
    check(we_count - w0, 0, "post_rst_wecount");
    goto_edge(base2 + 21);
    check(bus.ram_we_o, 1'b1, "post_rst_first_we");
    check(bus.ram_wdata_o, 8'h21, "post_rst_wdata0");

    // Collision: cs falls mid-scan, two requests
    goto_edge(base2 + 23);
    bus.cs_i = 1'b0;
    bus.rd_req_i = 1'b1;
    bus.rd_addr_i = 8'h06;
    a1 = ack_count;
    goto_edge(base2 + 24);
    check(err, 1'b0, "coll_latch_no_err");
    bus.rd_addr_i = 8'h01;
    goto_edge(base2 + 25);
    bus.rd_req_i = 1'b0;
    check(err, 1'b1, "coll_drop_err");
    goto_edge(base2 + 29);
    check(frame_cnt, 8'h01, "coll_frame_cnt");
    check(bus.ram_we_o, 1'b0, "coll_scan_end");
    goto_edge(base2 + 31);
    check(bus.rd_ack_o, 1'b0, "coll_ack_early");
    goto_edge(base2 + 32);
    check(bus.rd_ack_o, 1'b1, "coll_ack");
    check(bus.rd_data_o, 8'h27, "coll_data");
    $display("read addr=6 data=%0h (pending)", bus.rd_data_o);
    goto_edge(base2 + 38);
    check(ack_count - a1, 1, "coll_one_ack");

    // Wrap: 255 more frames bring frame_cnt back to 0
    goto_edge(base2 + 40);
    bus.cs_i = 1'b1;
    w0 = we_count;
    r0 = runs;
    b0 = bad_runs;
    goto_edge(base2 + 50);
    check(frame_cnt, 8'h02, "wrap_frame2");
    goto_edge(base2 + 5115);
    check(frame_cnt, 8'hFF, "wrap_frame255");
    goto_edge(base2 + 5135);
    check(frame_cnt, 8'h00, "wrap_frame0");
    check(we_count - w0, 255 * NG, "wrap_wecount");
    check(runs - r0, 255, "wrap_runs");
    check(bad_runs - b0, 0, "wrap_run_len");
    check(err, 1'b1, "err_sticky");
    $display("wrap frame_cnt=%0d writes=%0d", frame_cnt, we_count - w0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
